// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one ripple-carry adder among NUM_REQ
// requesters and returns each tagged result through a valid/ready channel.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   rr_ptr_next;
    logic              rsp_valid_reg;
    logic [WIDTH-1:0]  rsp_sum_reg;
    logic              rsp_cout_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic              busy_reg;

    logic [NUM_REQ-1:0] ge_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] hi_first;
    logic [NUM_REQ-1:0] all_first;
    logic [NUM_REQ:0]   hi_seen;
    logic [NUM_REQ:0]   all_seen;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_id;
    logic               can_grant;
    logic               any_req;
    logic               transfer;

    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_cin;
    logic [WIDTH:0]     carry;
    logic [WIDTH-1:0]   add_sum;

    // Two-pass priority: first valid index at or above rr_ptr, else the
    // lowest valid index overall (the wrap-around case).
    assign hi_seen[0]  = 1'b0;
    assign all_seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_arb
            assign ge_mask[gi]      = (ID_W'(gi) >= rr_ptr_reg);
            assign hi_req[gi]       = req_valid[gi] & ge_mask[gi];
            assign hi_first[gi]     = hi_req[gi] & ~hi_seen[gi];
            assign hi_seen[gi+1]    = hi_seen[gi] | hi_req[gi];
            assign all_first[gi]    = req_valid[gi] & ~all_seen[gi];
            assign all_seen[gi+1]   = all_seen[gi] | req_valid[gi];
        end
    endgenerate

    assign any_req      = all_seen[NUM_REQ];
    assign grant_onehot = hi_seen[NUM_REQ] ? hi_first : all_first;

    // A held result blocks new grants unless it is being consumed this cycle.
    assign can_grant = !rst && ((state_reg == IDLE) || (rsp_valid_reg && rsp_ready));
    assign req_ready = (can_grant && any_req) ? grant_onehot : '0;
    assign transfer  = |req_ready;

    always_comb begin
        grant_id = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_cin  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_onehot[i]) begin
                grant_id = grant_id | ID_W'(i);
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
                sel_cin  = req_cin[i];
            end
        end
    end

    assign rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Shared datapath: plain bitwise ripple-carry chain.
    assign carry[0] = sel_cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            assign add_sum[gi]  = sel_a[gi] ^ sel_b[gi] ^ carry[gi];
            assign carry[gi+1]  = (sel_a[gi] & sel_b[gi]) |
                                  (carry[gi] & (sel_a[gi] ^ sel_b[gi]));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_sum_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
            rsp_id_reg    <= '0;
            busy_reg      <= 1'b0;
        end else if (transfer) begin
            state_reg     <= RESP;
            rr_ptr_reg    <= rr_ptr_next;
            rsp_valid_reg <= 1'b1;
            rsp_sum_reg   <= add_sum;
            rsp_cout_reg  <= carry[WIDTH];
            rsp_id_reg    <= grant_id;
            busy_reg      <= 1'b1;
        end else if ((state_reg == RESP) && rsp_ready) begin
            // Result consumed, nothing new: data registers keep their value.
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = busy_reg;

endmodule
